// File: rtl/vga_timing_gen.sv
// Raster timing source: free-running pixel/line counters with decoded sync, blanking,
// line/frame strobes and a wrapping frame counter. Default timing is 640x480 @ 60 Hz.
module vga_timing_gen #(
  parameter int       H_VISIBLE = 640,
  parameter int       H_FRONT   = 16,
  parameter int       H_SYNC    = 96,
  parameter int       H_BACK    = 48,
  parameter int       V_VISIBLE = 480,
  parameter int       V_FRONT   = 10,
  parameter int       V_SYNC    = 2,
  parameter int       V_BACK    = 33,
  parameter bit       SYNC_POL  = 1'b0,
  parameter int       FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_tick,
  output logic               frame_tick,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Both totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic h_last;
  logic v_last;

  // Greater-or-equal so that a corrupted out-of-range count wraps back to 0.
  assign h_last = (pix_x >= H_LAST);
  assign v_last = (pix_y >= V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x     <= '0;
      pix_y     <= '0;
      frame_cnt <= '0;
    end else if (pix_en) begin
      pix_x <= h_last ? '0 : pix_x + 10'd1;
      if (h_last) begin
        pix_y <= v_last ? '0 : pix_y + 10'd1;
        if (v_last) frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  // Decoded straight from the counters so sync and blanking track position with zero skew.
  assign hsync = ((pix_x >= H_SYNC_BEG) && (pix_x < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  assign vsync = ((pix_y >= V_SYNC_BEG) && (pix_y < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;

  assign video_on   = (pix_x < H_VIS) && (pix_y < V_VIS);
  assign line_tick  = pix_en & h_last;
  assign frame_tick = line_tick & v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for line-level behaviour and a shrunken-timing
// instance (32x20 raster, 4-bit frame counter) for frame, vsync and wrap behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [9:0] x_a, y_a, x_b, y_b;
  logic       hs_a, vs_a, von_a, lt_a, ft_a;
  logic       hs_b, vs_b, von_b, lt_b, ft_b;
  logic [7:0] fc_a;
  logic [3:0] fc_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(en_a),
    .pix_x(x_a), .pix_y(y_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
    .line_tick(lt_a), .frame_tick(ft_a), .frame_cnt(fc_a)
  );

  // Small raster: H 16/4/6/6 (total 32, hsync 20..25), V 12/2/2/4 (total 20, vsync 14..15).
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
    .SYNC_POL(1'b0), .FRAME_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(en_b),
    .pix_x(x_b), .pix_y(y_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
    .line_tick(lt_b), .frame_tick(ft_b), .frame_cnt(fc_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One enabled frame of dut_b from (0,0), compared against an independent position model.
  task automatic sweep_b_frame(output int hs_low, output int vs_low, output int lt_cnt,
                               output int ft_cnt, output int ft_bad, output int err);
    int bx, by;
    bx = 0; by = 0;
    hs_low = 0; vs_low = 0; lt_cnt = 0; ft_cnt = 0; ft_bad = 0; err = 0;
    en_b = 1'b1;
    for (int i = 0; i < 640; i++) begin
      if (int'(x_b) != bx || int'(y_b) != by) err++;
      if (int'(von_b) != int'(bx < 16 && by < 12)) err++;
      if (int'(hs_b) != int'(!(bx >= 20 && bx < 26))) err++;
      if (int'(vs_b) != int'(!(by >= 14 && by < 16))) err++;
      if (!hs_b) hs_low++;
      if (!vs_b) vs_low++;
      if (lt_b) lt_cnt++;
      if (int'(lt_b) != int'(bx == 31)) err++;
      if (ft_b) begin
        ft_cnt++;
        if (!(bx == 31 && by == 19) || !lt_b) ft_bad++;
      end
      tick(1);
      if (bx == 31) begin
        bx = 0;
        by = (by == 19) ? 0 : by + 1;
      end else begin
        bx++;
      end
    end
    en_b = 1'b0;
  endtask

  initial begin
    int mx, my, hs_low, hs_first, hs_last, err;
    int vs_low, lt_cnt, ft_cnt, ft_bad, on_ticks, off_ticks;

    // Reset state
    #12;
    check("rst_x", int'(x_a), 0);
    check("rst_y", int'(y_a), 0);
    check("rst_fc", int'(fc_a), 0);
    check("rst_hs", int'(hs_a), 1);
    check("rst_vs", int'(vs_a), 1);
    check("rst_von", int'(von_a), 1);
    check("rst_lt", int'(lt_a), 0);
    check("rst_ft", int'(ft_a), 0);

    // First line end
    rst_n = 1'b1;
    en_a = 1'b1;
    tick(799);
    check("l0_x799", int'(x_a), 799);
    check("l0_y0", int'(y_a), 0);
    check("l0_lt", int'(lt_a), 1);
    check("l0_ft", int'(ft_a), 0);
    check("l0_von", int'(von_a), 0);
    tick(1);
    check("l1_x0", int'(x_a), 0);
    check("l1_y1", int'(y_a), 1);
    check("l1_lt", int'(lt_a), 0);
    check("l1_von", int'(von_a), 1);

    // Sweep line 1: hsync window and blanking
    mx = 0; my = 1; hs_low = 0; hs_first = -1; hs_last = -1; err = 0;
    for (int i = 0; i < 800; i++) begin
      if (int'(x_a) != mx || int'(y_a) != my) err++;
      if (int'(von_a) != int'(mx < 640)) err++;
      if (!hs_a) begin
        hs_low++;
        if (hs_first < 0) hs_first = mx;
        hs_last = mx;
      end
      tick(1);
      mx = (mx == 799) ? 0 : mx + 1;
      if (mx == 0) my++;
    end
    check("line_hs_low", hs_low, 96);
    check("line_hs_first", hs_first, 656);
    check("line_hs_last", hs_last, 751);
    check("line_err", err, 0);
    check("line_end_y", int'(y_a), 2);

    // Enable toggling every cycle: 800 advances, ticks only while enabled
    on_ticks = 0; off_ticks = 0;
    for (int i = 0; i < 1600; i++) begin
      en_a = (i % 2 == 0);
      #1;
      if (lt_a || ft_a) begin
        if (en_a) on_ticks++;
        else off_ticks++;
      end
      @(posedge clk);
      #1;
    end
    en_a = 1'b0;
    check("tog_x", int'(x_a), 0);
    check("tog_y", int'(y_a), 3);
    check("tog_on_ticks", on_ticks, 1);
    check("tog_off_ticks", off_ticks, 0);
    check("hold_b_x", int'(x_b), 0);

    // Full small frame
    sweep_b_frame(hs_low, vs_low, lt_cnt, ft_cnt, ft_bad, err);
    check("f1_hs_low", hs_low, 120);
    check("f1_vs_low", vs_low, 64);
    check("f1_lt_cnt", lt_cnt, 20);
    check("f1_ft_cnt", ft_cnt, 1);
    check("f1_ft_bad", ft_bad, 0);
    check("f1_err", err, 0);
    check("f1_x", int'(x_b), 0);
    check("f1_y", int'(y_b), 0);
    check("f1_fc", int'(fc_b), 1);

    // Frame counter wrap 15 -> 0 with sync positions unchanged on the wrapping frame
    en_b = 1'b1;
    tick(14 * 640);
    en_b = 1'b0;
    check("f15_fc", int'(fc_b), 15);
    check("f15_y", int'(y_b), 0);
    sweep_b_frame(hs_low, vs_low, lt_cnt, ft_cnt, ft_bad, err);
    check("f16_hs_low", hs_low, 120);
    check("f16_vs_low", vs_low, 64);
    check("f16_ft_cnt", ft_cnt, 1);
    check("f16_err", err, 0);
    check("f16_fc_wrap", int'(fc_b), 0);
    check("hold_a_x", int'(x_a), 0);
    check("hold_a_y", int'(y_a), 3);

    // Asynchronous reset mid-line (a in hsync, b in vsync)
    en_a = 1'b1;
    en_b = 1'b1;
    tick(451);
    en_b = 1'b0;
    tick(249);
    check("pre_rst_xa", int'(x_a), 700);
    check("pre_rst_hs", int'(hs_a), 0);
    check("pre_rst_yb", int'(y_b), 14);
    check("pre_rst_vs", int'(vs_b), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_xa", int'(x_a), 0);
    check("arst_ya", int'(y_a), 0);
    check("arst_hs", int'(hs_a), 1);
    check("arst_yb", int'(y_b), 0);
    check("arst_vs", int'(vs_b), 1);
    #2 rst_n = 1'b1;
    tick(1);
    check("post_rst_x", int'(x_a), 1);
    check("post_rst_y", int'(y_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
